// File: rtl/issue_ctrl.sv
// In-order issue controller: register scoreboard with RAW/WAW stalls,
// branch-wait/flush sequencing and a saturating stall-cycle counter.
module issue_ctrl #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             dec_wr_rd,
    input  logic             dec_ctrl,
    output logic             dec_ready,
    output logic             iss_valid,
    input  logic             ex_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             br_resolve,
    input  logic             br_taken,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      pend, pend_eff, pend_nxt;
    logic [OUT_W-1:0] out_cnt, out_cnt_eff, out_cnt_nxt;
    logic             wb_hit;
    logic             iss_wr;
    logic             hazard;

    // Scoreboard view with this cycle's writeback already applied (write-first RF).
    always_comb begin
        wb_hit      = wb_valid && (wb_rd != 5'd0) && pend[wb_rd];
        pend_eff    = pend;
        if (wb_hit) begin
            pend_eff[wb_rd] = 1'b0;
        end
        out_cnt_eff = out_cnt - OUT_W'(wb_hit);

        hazard = (dec_use_rs1 && (dec_rs1 != 5'd0) && pend_eff[dec_rs1])
              || (dec_use_rs2 && (dec_rs2 != 5'd0) && pend_eff[dec_rs2])
              || (dec_wr_rd && (dec_rd != 5'd0) && pend_eff[dec_rd])
              || (dec_wr_rd && (dec_rd != 5'd0) && (out_cnt_eff == OUT_W'(MAX_OUT)));

        dec_ready = !rst && (state == RUN) && !hazard && ex_ready;
        iss_valid = dec_valid && dec_ready;
        iss_wr    = iss_valid && dec_wr_rd && (dec_rd != 5'd0);

        // Set is applied after clear so a same-register set wins.
        pend_nxt = pend_eff;
        if (iss_wr) begin
            pend_nxt[dec_rd] = 1'b1;
        end
        out_cnt_nxt = out_cnt_eff + OUT_W'(iss_wr);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (iss_valid && dec_ctrl) begin
                    state_nxt = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_resolve) begin
                    state_nxt = br_taken ? FLUSH : RUN;
                end
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pend         <= 32'd0;
            out_cnt      <= '0;
            flush        <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            out_cnt <= out_cnt_nxt;
            flush   <= (state_nxt == FLUSH);
            if (dec_valid && !dec_ready && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios plus a randomized run against
// a behavioural scoreboard/branch model.
module tb_issue_ctrl;

    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned CNT_W   = 32;

    logic             clk;
    logic             rst;
    logic             dec_valid;
    logic [4:0]       dec_rd, dec_rs1, dec_rs2;
    logic             dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_ctrl;
    logic             dec_ready, iss_valid;
    logic             ex_ready;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             br_resolve, br_taken;
    logic             flush;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [31:0]        m_pend;
    int               m_cnt;
    bit               m_brwait;
    bit               m_flush;
    logic [CNT_W-1:0] m_stall;

    issue_ctrl #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_wr_rd(dec_wr_rd), .dec_ctrl(dec_ctrl),
        .dec_ready(dec_ready), .iss_valid(iss_valid), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .br_resolve(br_resolve), .br_taken(br_taken),
        .flush(flush), .stall_cycles(stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Model: can the decoder's current instruction issue this cycle?
    function automatic bit m_ready();
        bit [31:0] eff;
        int        ce;
        bit        haz;
        if (rst || m_brwait || m_flush || !ex_ready) return 1'b0;
        eff = m_pend;
        ce  = m_cnt;
        if (wb_valid && eff[wb_rd]) begin
            eff[wb_rd] = 1'b0;
            ce = ce - 1;
        end
        haz = (dec_use_rs1 && dec_rs1 != 0 && eff[dec_rs1])
           || (dec_use_rs2 && dec_rs2 != 0 && eff[dec_rs2])
           || (dec_wr_rd && dec_rd != 0 && (eff[dec_rd] || ce == int'(MAX_OUT)));
        return !haz;
    endfunction

    // Advance one clock and apply the same cycle to the model.
    task automatic step();
        bit r, iv;
        r  = m_ready();
        iv = dec_valid && r;
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_cnt = 0; m_brwait = 0; m_flush = 0; m_stall = '0;
        end else begin
            if (wb_valid && m_pend[wb_rd]) begin
                m_pend[wb_rd] = 1'b0;
                m_cnt = m_cnt - 1;
            end
            if (iv && dec_wr_rd && dec_rd != 0) begin
                m_pend[dec_rd] = 1'b1;
                m_cnt = m_cnt + 1;
            end
            if (m_flush) m_flush = 1'b0;
            else if (m_brwait) begin
                if (br_resolve) begin
                    m_brwait = 1'b0;
                    m_flush  = br_taken;
                end
            end else if (iv && dec_ctrl) m_brwait = 1'b1;
            if (dec_valid && !r && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
        end
        #1;
    endtask

    task automatic set_idle();
        dec_valid = 0; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
        dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr_rd = 0; dec_ctrl = 0;
        ex_ready = 1; wb_valid = 0; wb_rd = 0; br_resolve = 0; br_taken = 0;
    endtask

    task automatic set_dec(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic wr, input logic ctrl);
        dec_valid = 1; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr; dec_ctrl = ctrl;
    endtask

    task automatic drain(input logic [4:0] rd);
        set_idle();
        wb_valid = 1; wb_rd = rd;
        step();
        set_idle();
    endtask

    task automatic test_reset();
        rst = 1;
        set_dec(3, 1, 2, 1, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dec_ready: got %b want 0", dec_ready); end
            n_checks++;
            if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
            step();
        end
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_checks++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
        n_checks++;
        if (dut.pend !== 32'd0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", dut.pend); end
        n_checks++;
        if (int'(dut.out_cnt) != 0) begin n_fail++; $display("FAIL reset_out_cnt: got %0d want 0", dut.out_cnt); end
    endtask

    // Continues at the first post-reset negedge with ADD x3,x1,x2 presented.
    task automatic test_first_issue();
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL first_issue: got %b want 1", iss_valid); end
        step();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dut.pend !== 32'h0000_0008) begin n_fail++; $display("FAIL first_pend: got %h want 00000008", dut.pend); end
        n_checks++;
        if (int'(dut.out_cnt) != 1) begin n_fail++; $display("FAIL first_out_cnt: got %0d want 1", dut.out_cnt); end
        step();
    endtask

    task automatic test_raw();
        set_dec(4, 3, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall cyc%0d: got %b want 0", i, dec_ready); end
            step();
        end
        wb_valid = 1; wb_rd = 3;
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL raw_issue_on_wb: got %b want 1", iss_valid); end
        step();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (stall_cycles !== 32'd4) begin n_fail++; $display("FAIL raw_stall_cnt: got %0d want 4", stall_cycles); end
        n_checks++;
        if (dut.pend !== 32'h0000_0010) begin n_fail++; $display("FAIL raw_pend: got %h want 00000010", dut.pend); end
        step();
        drain(4);
    endtask

    task automatic test_x0_waw();
        set_dec(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL x0_issue cyc%0d: got %b want 1", i, iss_valid); end
            step();
        end
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dut.pend !== 32'd0) begin n_fail++; $display("FAIL x0_pend: got %h want 0", dut.pend); end
        step();
        set_dec(5, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL waw_first: got %b want 1", iss_valid); end
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall cyc%0d: got %b want 0", i, dec_ready); end
            step();
        end
        wb_valid = 1; wb_rd = 5;
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL waw_issue_on_wb: got %b want 1", iss_valid); end
        step();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dut.pend !== 32'h0000_0020 || int'(dut.out_cnt) != 1) begin
            n_fail++; $display("FAIL waw_state: pend %h cnt %0d want 00000020/1", dut.pend, dut.out_cnt);
        end
        step();
        drain(5);
    endtask

    task automatic test_max_out();
        for (int r = 1; r <= 4; r++) begin
            set_dec(5'(r), 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            n_checks++;
            if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL max_fill x%0d: got %b want 1", r, iss_valid); end
            step();
        end
        set_dec(6, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        n_checks++;
        if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL max_fifth_stall: got %b want 0", dec_ready); end
        step();
        set_dec(0, 10, 11, 1, 1, 0, 0);
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL max_store_issue: got %b want 1", iss_valid); end
        step();
        set_dec(6, 0, 0, 0, 0, 1, 0);
        wb_valid = 1; wb_rd = 1;
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL max_fifth_on_wb: got %b want 1", iss_valid); end
        step();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dut.pend !== 32'h0000_005C || int'(dut.out_cnt) != 4) begin
            n_fail++; $display("FAIL max_state: pend %h cnt %0d want 0000005c/4", dut.pend, dut.out_cnt);
        end
        step();
        drain(2); drain(3); drain(4); drain(6);
        @(negedge clk);
        n_checks++;
        if (int'(dut.out_cnt) != 0) begin n_fail++; $display("FAIL max_drained: got %0d want 0", dut.out_cnt); end
        step();
    endtask

    task automatic test_branch(input bit taken);
        // br_resolve outside BR_WAIT has no effect
        set_idle();
        br_resolve = 1; br_taken = 1;
        step();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (flush !== 1'b0 || dec_ready !== 1'b1) begin
            n_fail++; $display("FAIL br_ignored: flush %b ready %b want 0/1", flush, dec_ready);
        end
        step();
        set_dec(0, 1, 2, 1, 1, 0, 1);
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL br_issue t%0d: got %b want 1", taken, iss_valid); end
        step();
        set_dec(8, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin br_resolve = 1; br_taken = taken; end
            @(negedge clk);
            n_checks++;
            if (iss_valid !== 1'b0 || flush !== 1'b0) begin
                n_fail++; $display("FAIL br_wait t%0d N+%0d: iss %b flush %b want 0/0", taken, i, iss_valid, flush);
            end
            step();
        end
        br_resolve = 0; br_taken = 0;
        if (taken) begin
            @(negedge clk);
            n_checks++;
            if (flush !== 1'b1 || iss_valid !== 1'b0) begin
                n_fail++; $display("FAIL br_flush: flush %b iss %b want 1/0", flush, iss_valid);
            end
            step();
        end
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1 || flush !== 1'b0) begin
            n_fail++; $display("FAIL br_resume t%0d: iss %b flush %b want 1/0", taken, iss_valid, flush);
        end
        step();
        drain(8);
    endtask

    task automatic test_simul();
        set_dec(7, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL simul_first: got %b want 1", iss_valid); end
        step();
        wb_valid = 1; wb_rd = 7;
        @(negedge clk);
        n_checks++;
        if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL simul_issue: got %b want 1", iss_valid); end
        step();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dut.pend !== 32'h0000_0080 || int'(dut.out_cnt) != 1) begin
            n_fail++; $display("FAIL simul_state: pend %h cnt %0d want 00000080/1", dut.pend, dut.out_cnt);
        end
        step();
        drain(7);
    endtask

    task automatic test_reset_brwait();
        set_dec(9, 0, 0, 0, 0, 1, 0);
        step();
        set_dec(0, 0, 0, 0, 0, 0, 1);
        step();
        set_idle();
        @(negedge clk);
        n_checks++;
        if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL rstbr_in_wait: got %b want 0", dec_ready); end
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (dut.pend !== 32'd0 || int'(dut.out_cnt) != 0 || dec_ready !== 1'b1 || flush !== 1'b0) begin
            n_fail++; $display("FAIL rstbr_cleared: pend %h cnt %0d ready %b flush %b want 0/0/1/0",
                               dut.pend, dut.out_cnt, dec_ready, flush);
        end
        step();
        drain(9);
        @(negedge clk);
        n_checks++;
        if (int'(dut.out_cnt) != 0) begin n_fail++; $display("FAIL rstbr_stale_wb: got %0d want 0", dut.out_cnt); end
        step();
    endtask

    task automatic test_random();
        rst = 1; set_idle();
        step();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_rd      = 5'($urandom_range(0, 7));
            dec_rs1     = 5'($urandom_range(0, 7));
            dec_rs2     = 5'($urandom_range(0, 7));
            dec_use_rs1 = 1'($urandom_range(0, 1));
            dec_use_rs2 = 1'($urandom_range(0, 1));
            dec_wr_rd   = ($urandom_range(0, 3) != 0);
            dec_ctrl    = ($urandom_range(0, 7) == 0);
            ex_ready    = ($urandom_range(0, 4) != 0);
            wb_valid    = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 7));
            br_resolve  = ($urandom_range(0, 3) == 0);
            br_taken    = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (dec_ready !== m_ready() || iss_valid !== (dec_valid && m_ready())) begin
                n_fail++; $display("FAIL rand_ready c%0d: ready %b iss %b want %b/%b",
                                   c, dec_ready, iss_valid, m_ready(), dec_valid && m_ready());
            end
            n_checks++;
            if (flush !== m_flush || stall_cycles !== m_stall) begin
                n_fail++; $display("FAIL rand_flush_stall c%0d: flush %b stall %0d want %b/%0d",
                                   c, flush, stall_cycles, m_flush, m_stall);
            end
            n_checks++;
            if (dut.pend !== m_pend || int'(dut.out_cnt) != m_cnt) begin
                n_fail++; $display("FAIL rand_scoreboard c%0d: pend %h cnt %0d want %h/%0d",
                                   c, dut.pend, dut.out_cnt, m_pend, m_cnt);
            end
            step();
        end
        rst = 0;
        set_idle();
    endtask

    initial begin
        m_pend = 0; m_cnt = 0; m_brwait = 0; m_flush = 0; m_stall = '0;
        rst = 1;
        set_idle();
        test_reset();
        test_first_issue();
        test_raw();
        test_x0_waw();
        test_max_out();
        test_branch(1'b1);
        test_branch(1'b0);
        test_simul();
        test_reset_brwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
